// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_t : control states (IDLE -> RUN -> FIN -> IDLE)
//   MULT_WA_DEF  : default multiplier (A) width
//   MULT_WB_DEF  : default multiplicand (B) / result (Y) width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } mult_state_t;

  localparam int unsigned MULT_WA_DEF = 4;
  localparam int unsigned MULT_WB_DEF = 4;

endpackage

// File: rtl/banderas_mult.sv
// Combinational Z/N/C/V flag generation for a WA x WB product.
// Ports:
//   p_i           : full product (WA+WB bits)
//   signed_mode_i : 1 = product of two's-complement operands
//   z_o           : truncated result Y = p_i[WB-1:0] is zero
//   n_o           : Y[WB-1]
//   c_o           : unsigned only, upper product bits non-zero
//   v_o           : signed only, product not representable in WB-bit signed
// Shared with other ALU units, so kept purely combinational.
module banderas_mult #(
  parameter int unsigned WA = 4,
  parameter int unsigned WB = 4
) (
  input  logic [WA+WB-1:0] p_i,
  input  logic             signed_mode_i,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o,
  output logic             v_o
);

  logic [WB-1:0] y;
  logic [WA-1:0] upper;
  logic [WA:0]   sign_ext;  // bits that must all match the Y sign bit

  always_comb begin
    y        = p_i[WB-1:0];
    upper    = p_i[WA+WB-1:WB];
    sign_ext = p_i[WA+WB-1:WB-1];
    z_o      = (y == '0);
    n_o      = y[WB-1];
    c_o      = !signed_mode_i && (upper != '0);
    v_o      = signed_mode_i && !((&sign_ext) || (~|sign_ext));
  end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Operands are converted to magnitudes at start, multiplied unsigned and the
// sign is reapplied in FIN, so signed and unsigned share one datapath.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, sampled only in IDLE
//   clr                 : synchronous abort, priority over start/progress
//   signed_mode, A, B   : operands and mode, captured with start
//   busy                : operation in flight
//   done                : one-cycle pulse, results valid from this cycle on
//   P, Y                : full product and WB-bit truncated result
//   Z, N, C, V          : flags, registered together with P
// All outputs come straight from flops; results hold until the next FIN.
module multiplicador_secuencial
  import mult_pkg::*;
#(
  parameter int unsigned WA = MULT_WA_DEF,
  parameter int unsigned WB = MULT_WB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             signed_mode,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] P,
  output logic [WB-1:0]    Y,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int unsigned W    = WA + WB;
  localparam int unsigned CntW = $clog2(WA + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WA - 1);

  mult_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WA-1:0]   mplier_q, mplier_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            sign_q, sign_d;
  logic            smode_q, smode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    p_q, p_d;
  logic            z_q, z_d;
  logic            n_q, n_d;
  logic            c_q, c_d;
  logic            v_q, v_d;

  logic [WA-1:0]   mag_a;
  logic [WB-1:0]   mag_b;
  logic [W-1:0]    p_fin;
  logic            z_fin, n_fin, c_fin, v_fin;

  // Negation of the most-negative value wraps to itself, which read unsigned
  // is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    mag_a = (signed_mode && A[WA-1]) ? -A : A;
    mag_b = (signed_mode && B[WB-1]) ? -B : B;
    p_fin = sign_q ? -acc_q : acc_q;
  end

  banderas_mult #(
    .WA (WA),
    .WB (WB)
  ) u_banderas (
    .p_i           (p_fin),
    .signed_mode_i (smode_q),
    .z_o           (z_fin),
    .n_o           (n_fin),
    .c_o           (c_fin),
    .v_o           (v_fin)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    smode_d  = smode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    p_d      = p_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;

    unique case (state_q)
      IDLE: begin
        // clr in IDLE simply masks start
        if (start && !clr) begin
          mplier_d = mag_a;
          mcand_d  = {{WA{1'b0}}, mag_b};
          sign_d   = signed_mode && (A[WA-1] ^ B[WB-1]);
          smode_d  = signed_mode;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mplier_d = mplier_q >> 1;
          mcand_d  = mcand_q << 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!clr) begin
          p_d    = p_fin;
          z_d    = z_fin;
          n_d    = n_fin;
          c_d    = c_fin;
          v_d    = v_fin;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      smode_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      smode_q  <= smode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      p_q      <= p_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
  assign Y    = p_q[WB-1:0];
  assign Z    = z_q;
  assign N    = n_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial at WA = WB = 4.
module tb_multiplicador_secuencial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clr;
  logic       signed_mode;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;
  logic [3:0] Y;
  logic       Z, N, C, V;

  int vectors;
  int miscompares;

  multiplicador_secuencial #(
    .WA (4),
    .WB (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clr         (clr),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .P           (P),
    .Y           (Y),
    .Z           (Z),
    .N           (N),
    .C           (C),
    .V           (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after an edge; start is sampled by the next edge (edge t) and
  // the task returns #1 after edge t.
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic sm);
    A = a;
    B = b;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after edge t until done is seen; lat = -1 on timeout.
  task automatic wait_done(input int already, output int lat);
    lat = -1;
    for (int k = already + 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if ({busy, done, P, Y, Z, N, C, V} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b P=%h Y=%h ZNCV=%b%b%b%b exp 0 0 00 0 1000",
               busy, done, P, Y, Z, N, C, V);
    end
  endtask

  task automatic test_unsigned_3x5;
    int lat;
    launch(4'd3, 4'd5, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL u3x5_busy got %b exp 1", busy);
    end
    wait_done(0, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("FAIL u3x5_latency got %0d exp 5", lat);
    end
    vectors++;
    if ({P, Y, Z, N, C, V, busy} !== {8'h0F, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL u3x5_result got P=%h Y=%h ZNCV=%b%b%b%b busy=%b exp 0F F 0100 0",
               P, Y, Z, N, C, V, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || P !== 8'h0F) begin
      miscompares++;
      $display("FAIL u3x5_done_pulse got done=%b P=%h exp 0 0F", done, P);
    end
  endtask

  task automatic test_unsigned_max_zero;
    int lat;
    launch(4'd15, 4'd15, 1'b0);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'hE1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL u15x15 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 E1 1 0010",
               lat, P, Y, Z, N, C, V);
    end
    launch(4'd0, 4'd9, 1'b0);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL u0x9 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 00 0 1000",
               lat, P, Y, Z, N, C, V);
    end
  endtask

  task automatic test_signed_neg;
    int lat;
    launch(4'b1101, 4'b0101, 1'b1);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'hF1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL s_m3x5 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 F1 1 0001",
               lat, P, Y, Z, N, C, V);
    end
  endtask

  task automatic test_signed_bounds;
    int lat;
    launch(4'b1000, 4'b1000, 1'b1);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'h40, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL s_m8xm8 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 40 0 1001",
               lat, P, Y, Z, N, C, V);
    end
    launch(4'd2, 4'd3, 1'b1);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'h06, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL s_2x3 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 06 6 0000",
               lat, P, Y, Z, N, C, V);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    launch(4'd3, 4'd5, 1'b0);
    @(posedge clk);
    #1;
    // New request with different operands while busy, sampled at edge t+2
    A = 4'd7;
    B = 4'd7;
    signed_mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'h0F, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_start got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 0F F 0100",
               lat, P, Y, Z, N, C, V);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(4'd15, 4'd15, 1'b0);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || P !== 8'hE1) begin
      miscompares++;
      $display("FAIL b2b_first got lat=%0d P=%h exp 5 E1", lat, P);
    end
    // Start issued during the done cycle
    launch(4'd2, 4'd3, 1'b0);
    vectors++;
    if (busy !== 1'b1 || P !== 8'hE1) begin
      miscompares++;
      $display("FAIL b2b_accept got busy=%b P=%h exp 1 E1", busy, P);
    end
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Z, N, C, V} !== {8'h06, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_second got lat=%0d P=%h ZNCV=%b%b%b%b exp 5 06 0000",
               lat, P, Z, N, C, V);
    end
  endtask

  task automatic test_clr;
    int lat;
    int seen;
    launch(4'd3, 4'd5, 1'b0);
    wait_done(0, lat);
    @(posedge clk);
    #1;
    launch(4'd15, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_abort got busy=%b done=%b exp 0 0", busy, done);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL clr_no_done got %0d active cycles exp 0", seen);
    end
    vectors++;
    if ({P, Y, Z, N, C, V} !== {8'h0F, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL clr_retain got P=%h Y=%h ZNCV=%b%b%b%b exp 0F F 0100",
               P, Y, Z, N, C, V);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    launch(4'd15, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, P, Y, Z, N, C, V} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b done=%b P=%h Y=%h ZNCV=%b%b%b%b exp 0 0 00 0 1000",
               busy, done, P, Y, Z, N, C, V);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launch(4'd3, 4'd5, 1'b0);
    wait_done(0, lat);
    vectors++;
    if (lat !== 5 || {P, Y, Z, N, C, V} !== {8'h0F, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset_3x5 got lat=%0d P=%h Y=%h ZNCV=%b%b%b%b exp 5 0F F 0100",
               lat, P, Y, Z, N, C, V);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    clr         = 1'b0;
    signed_mode = 1'b0;
    A           = 4'd0;
    B           = 4'd0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_unsigned_3x5();
    test_unsigned_max_zero();
    test_signed_neg();
    test_signed_bounds();
    test_ignore_start();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
